// File: rtl/riscv_instr_pkg.sv
// Shared RV32 instruction encodings plus the M-extension sequencer's state
// type, iteration count and op-classification helpers.
package riscv_instr_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [6:0] {
    INSTR_ILLEGAL = 7'd0,
    INSTR_ADD     = 7'd1,
    INSTR_SUB     = 7'd2,
    INSTR_MUL     = 7'd48,
    INSTR_MULH    = 7'd49,
    INSTR_MULHSU  = 7'd50,
    INSTR_MULHU   = 7'd51,
    INSTR_DIV     = 7'd52,
    INSTR_DIVU    = 7'd53,
    INSTR_REM     = 7'd54,
    INSTR_REMU    = 7'd55
  } riscv_instr_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic logic is_muldiv_op(riscv_instr_e op);
    return op inside {INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU,
                      INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU};
  endfunction

  function automatic logic is_mul_op(riscv_instr_e op);
    return op inside {INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU};
  endfunction

  function automatic logic is_signed_div(riscv_instr_e op);
    return op inside {INSTR_DIV, INSTR_REM};
  endfunction

  function automatic logic is_rem_op(riscv_instr_e op);
    return op inside {INSTR_REM, INSTR_REMU};
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step pulse,
// operand magnitudes captured on load.
module muldiv_div_core
  import riscv_instr_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, div_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      div_q <= divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execution controller: single-cycle multiply, 32-step restoring divide,
// sign fix-up and a held result with valid/ready handshake.
module muldiv_sequencer
  import riscv_instr_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  muldiv_state_e   state;
  riscv_instr_e    in_op_e;
  riscv_instr_e    op_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt;

  logic        accept;
  logic        acc_signed;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] special_res;
  logic        div_load;

  logic        a_ext;
  logic        b_ext;
  logic [63:0] prod;
  logic [31:0] mul_res;

  logic [31:0] quo;
  logic [31:0] rem;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] fix_res;

  assign in_op_e  = riscv_instr_e'(in_op);
  assign in_ready = (state == IDLE) && !flush;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // Classify the offered divide and precompute magnitudes / early results.
  always_comb begin
    acc_signed  = is_signed_div(in_op_e);
    div_zero    = (in_b == 32'h0);
    div_ovf     = acc_signed && (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);
    mag_a       = (acc_signed && in_a[31]) ? 32'(-in_a) : in_a;
    mag_b       = (acc_signed && in_b[31]) ? 32'(-in_b) : in_b;
    special_res = 32'h0;
    if (div_zero) begin
      special_res = is_rem_op(in_op_e) ? in_a : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_res = is_rem_op(in_op_e) ? 32'h0 : 32'h8000_0000;
    end
    div_load = accept && is_muldiv_op(in_op_e) && !is_mul_op(in_op_e)
               && !div_zero && !div_ovf;
  end

  // Low 64 bits of the product of 64-bit sign/zero-extended operands.
  always_comb begin
    a_ext   = (op_q inside {INSTR_MUL, INSTR_MULH, INSTR_MULHSU}) && a_q[31];
    b_ext   = (op_q inside {INSTR_MUL, INSTR_MULH}) && b_q[31];
    prod    = {{32{a_ext}}, a_q} * {{32{b_ext}}, b_q};
    mul_res = (op_q == INSTR_MUL) ? prod[31:0] : prod[63:32];
  end

  muldiv_div_core u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (state == DIV),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem)
  );

  // Quotient negative when operand signs differ; remainder follows the dividend.
  always_comb begin
    q_neg   = is_signed_div(op_q) && (a_q[31] ^ b_q[31]);
    r_neg   = is_signed_div(op_q) && a_q[31];
    fix_res = is_rem_op(op_q) ? (r_neg ? 32'(-rem) : rem)
                              : (q_neg ? 32'(-quo) : quo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= INSTR_ILLEGAL;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= in_op_e;
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
            cnt   <= '0;
            if (!is_muldiv_op(in_op_e)) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= '0;
              out_tag    <= in_tag;
            end else if (is_mul_op(in_op_e)) begin
              state <= MUL;
            end else if (div_zero || div_ovf) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= special_res;
              out_tag    <= in_tag;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          state      <= DONE;
          out_valid  <= 1'b1;
          out_result <= mul_res;
          out_tag    <= tag_q;
        end
        DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_ITERS - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          state      <= DONE;
          out_valid  <= 1'b1;
          out_result <= fix_res;
          out_tag    <= tag_q;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle execution controller for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) emitted by the instruction decoder. It sits in the execute stage beside the single-cycle ALU. It accepts one decoded M-extension operation at a time over a valid/ready handshake and sequences a one-cycle multiply or a 32-iteration restoring divide. It returns the 32-bit result with its destination tag and holds the pipeline via `in_ready` while busy.

## Interface
- `TAG_W`, default 5: width of the destination tag carried through (rd index).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: kill any in-flight operation.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: sequencer can accept.
- `in_op` in 7: `riscv_instr_e` value, INSTR_MUL..INSTR_REMU.
- `in_a` in 32: rs1 operand.
- `in_b` in 32: rs2 operand.
- `in_tag` in TAG_W: destination tag.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `out_result` out 32: result.
- `out_tag` out TAG_W: tag of the result.
- `busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Reset values: state IDLE, `out_valid` 0, `out_result` 0, `out_tag` 0, `busy` 0, iteration counter 0.
- `in_ready` = (state == IDLE) && !flush. An operation is accepted when `in_valid` && `in_ready`. Operands, op and tag are latched on acceptance.
- Transitions out of IDLE on accept:
  - MUL-class op → MUL.
  - DIV/DIVU/REM/REMU with `in_b` == 0 or signed overflow → DONE directly.
  - Any other divide → DIV.
  - Any other `in_op` value: result 0, → DONE.
- MUL: forms the 64-bit product with sign-extension per op. MUL/MULH treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned. MUL returns [31:0]; the others return [63:32]. → DONE.
- DIV: operates on magnitudes for signed ops. One restoring step per cycle: shift the remainder/quotient pair left, trial-subtract the divisor, set the quotient bit. The counter runs 0..31; at 31 → FIX.
- FIX: applies sign corrections. The quotient is negated if the signs of a and b differ (signed ops). The remainder takes the sign of the dividend. Selects quotient (DIV/DIVU) or remainder (REM/REMU). → DONE.
- Special cases, RISC-V mandated:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = a.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- DONE: `out_valid` = 1. Result and tag are held stable until `out_ready`. When `out_valid` && `out_ready` → IDLE.
- `flush` (highest priority): state → IDLE at the next edge from any state. `out_valid` drops; the counter clears; no result is delivered. `flush` during a DONE handshake also discards that result.
- `rst_n` asserted mid-operation: immediate return to reset values, independent of `clk`.

## Timing
Latencies are counted from the accept edge to the first cycle `out_valid` = 1:
- MUL-class: 2 cycles.
- Regular divide: 34 cycles (32 DIV + 1 FIX + 1 DONE entry).
- Divide special cases and invalid op: 1 cycle.
- Throughput: one operation in flight. A new op is accepted no earlier than the cycle after the output handshake, because `in_ready` is 0 in DONE.
- `out_valid` is registered. `out_result` and `out_tag` only change on entering DONE or on reset.

## Structure
- In the shared `riscv_instr_pkg`:
  - `muldiv_state_e` {IDLE, MUL, DIV, FIX, DONE}.
  - Constant `DIV_ITERS` = 32.
  - Helper function `is_muldiv_op(riscv_instr_e)`.
- Sub-module `muldiv_div_core`: the remainder/quotient/divisor registers and one restoring step per enable pulse. It has ports `step`, `load`, magnitudes in, and quotient/remainder out.
- The FSM, the multiplier, and sign handling live in the top module.

## Test plan
- MUL a=7, b=0xFFFFFFFD → 0xFFFFFFEB at 2 cycles. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. All at exactly 34 cycles, with `out_tag` equal to the input tag.
- Special cases, each at 1-cycle latency:
  - DIVU 0x1234/0 → 0xFFFFFFFF.
  - REM 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Backpressure: hold `out_ready` = 0 for 10 cycles in DONE. Result and tag must stay stable and `in_ready` stay 0. Raise `out_ready`: IDLE next cycle, and the next op is accepted the following cycle.
- `flush` at DIV iteration 15 → IDLE next edge, `out_valid` never asserted. A following MULHU then returns the correct result.
- Assert `rst_n` low asynchronously at DIV iteration 20 → all outputs at reset values before the next edge. After deassertion `in_ready` = 1.
